cnn_seq_ctrl: RTL

Top-level sequencer for the CNN core. It packs the incoming UART image bytes into the input image RAM and starts each layer engine in order: conv_0, max_0, conv_1, max_1, dense_4. It then scans the final class-score RAM for the argmax and hands the predicted label to the UART transmitter. It sits between the UART receiver/transmitter and the layer engines, replacing ad-hoc start chaining between layers.

---
 rtl/cnn_seq_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/cnn_seq_ctrl.sv
// CNN core sequencer: loads a UART image into the image RAM, chains the layer
// engines one after another, then scans the class scores for the argmax and sends the label.
module cnn_seq_ctrl #(
  parameter int IMG_BYTES = 98,
  parameter int N_LAYERS  = 5,
  parameter int N_CLASS   = 10,
  parameter int SCORE_W   = 18
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          rx_data,
  input  logic                rx_rdy,
  output logic                img_we,
  output logic [6:0]          img_addr,
  output logic [7:0]          img_wdata,
  output logic [N_LAYERS-1:0] layer_start,
  input  logic [N_LAYERS-1:0] layer_done,
  output logic [3:0]          score_addr,
  input  logic [SCORE_W-1:0]  score_q,
  output logic                trmt,
  output logic [7:0]          tx_data,
  output logic                busy,
  output logic                ovr
);

  typedef enum logic [2:0] {LOAD, START, WAIT, SCAN, XMIT} state_t;

  localparam logic [6:0]          LAST_BYTE = 7'(IMG_BYTES - 1);
  localparam logic [6:0]          NCLS      = 7'(N_CLASS);
  localparam logic [2:0]          LAST_IDX  = 3'(N_LAYERS - 1);
  localparam logic [N_LAYERS-1:0] LS0       = {{(N_LAYERS-1){1'b0}}, 1'b1};

  state_t                     state_q, state_d;
  logic [6:0]                 cnt_q, cnt_d;
  logic [2:0]                 idx_q, idx_d;
  logic signed [SCORE_W-1:0]  max_q, max_d;
  logic [3:0]                 best_q, best_d;
  logic                       img_we_q, img_we_d;
  logic [6:0]                 img_addr_q, img_addr_d;
  logic [7:0]                 img_wdata_q, img_wdata_d;
  logic [N_LAYERS-1:0]        layer_start_q, layer_start_d;
  logic [3:0]                 score_addr_q, score_addr_d;
  logic                       trmt_q, trmt_d;
  logic [7:0]                 tx_data_q, tx_data_d;
  logic                       busy_q, busy_d;
  logic                       ovr_q, ovr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= LOAD;
      cnt_q         <= '0;
      idx_q         <= '0;
      max_q         <= '0;
      best_q        <= '0;
      img_we_q      <= 1'b0;
      img_addr_q    <= '0;
      img_wdata_q   <= '0;
      layer_start_q <= '0;
      score_addr_q  <= '0;
      trmt_q        <= 1'b0;
      tx_data_q     <= '0;
      busy_q        <= 1'b0;
      ovr_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      max_q         <= max_d;
      best_q        <= best_d;
      img_we_q      <= img_we_d;
      img_addr_q    <= img_addr_d;
      img_wdata_q   <= img_wdata_d;
      layer_start_q <= layer_start_d;
      score_addr_q  <= score_addr_d;
      trmt_q        <= trmt_d;
      tx_data_q     <= tx_data_d;
      busy_q        <= busy_d;
      ovr_q         <= ovr_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    max_d         = max_q;
    best_d        = best_q;
    img_we_d      = 1'b0;
    img_addr_d    = img_addr_q;
    img_wdata_d   = img_wdata_q;
    layer_start_d = '0;
    score_addr_d  = score_addr_q;
    trmt_d        = 1'b0;
    tx_data_d     = tx_data_q;
    busy_d        = busy_q;
    ovr_d         = ovr_q | (rx_rdy && (state_q != LOAD));

    case (state_q)
      LOAD: begin
        if (rx_rdy) begin
          img_we_d    = 1'b1;
          img_addr_d  = cnt_q;
          img_wdata_d = rx_data;
          if (cnt_q == LAST_BYTE) begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = START;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
      end
      START: begin
        layer_start_d = LS0 << idx_q;
        busy_d        = 1'b1;
        state_d       = WAIT;
      end
      WAIT: begin
        // A done pulse coincident with our own start pulse is not trusted.
        if ((layer_start_q == '0) && layer_done[idx_q]) begin
          if (idx_q == LAST_IDX) begin
            cnt_d        = '0;
            score_addr_d = '0;
            state_d      = SCAN;
          end else begin
            idx_d         = idx_q + 3'd1;
            layer_start_d = LS0 << (idx_q + 3'd1);
          end
        end
      end
      SCAN: begin
        // cnt_q counts cycles in SCAN; the score for address cnt_q-1 is on score_q.
        if (cnt_q != 7'd0) begin
          if ((cnt_q == 7'd1) || ($signed(score_q) > max_q)) begin
            max_d  = $signed(score_q);
            best_d = cnt_q[3:0] - 4'd1;
          end
        end
        if (cnt_q == NCLS) begin
          trmt_d       = 1'b1;
          tx_data_d    = {4'd0, best_d};
          score_addr_d = '0;
          cnt_d        = '0;
          state_d      = XMIT;
        end else begin
          cnt_d        = cnt_q + 7'd1;
          score_addr_d = ((cnt_q + 7'd1) < NCLS) ? (cnt_q[3:0] + 4'd1) : 4'd0;
        end
      end
      XMIT: begin
        busy_d  = 1'b0;
        state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  assign img_we      = img_we_q;
  assign img_addr    = img_addr_q;
  assign img_wdata   = img_wdata_q;
  assign layer_start = layer_start_q;
  assign score_addr  = score_addr_q;
  assign trmt        = trmt_q;
  assign tx_data     = tx_data_q;
  assign busy        = busy_q;
  assign ovr         = ovr_q;

endmodule
